// File: rtl/dpi_call_arbiter.sv
// dpi_call_arbiter
//   Shares one host-side DPI call channel among N_REQ hardware requesters.
//   A round-robin winner is latched and serialized as one header beat
//   ({grant id, element count, function id}) followed by one beat per
//   argument word. The host answers with a return-value beat followed by
//   output-array beats, which are collected into a packed result and
//   presented to the winner with a one-cycle rsp_valid_o pulse. Exactly one
//   call is in flight at a time.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i / req_ready_o per-requester request / one-hot accept strobe
//   req_func_id_i, req_len_i, req_args_i
//                             packed per-requester function id, element
//                             count and argument array (word i at [i*32+:32])
//   rsp_valid_o               one-cycle completion pulse to the winner
//   rsp_ret_o, rsp_data_o     return value and output array, held until the
//                             next completion
//   busy_o                    high while a call is in progress
//   call_valid_o/ready_i/data_o/last_o   outgoing call beat stream
//   ret_valid_i/ready_o/data_i/last_i    incoming return beat stream
module dpi_call_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_WORDS   = 4,
  parameter int FUNC_ID_W = 8,
  parameter int LEN_W     = $clog2(N_WORDS + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_valid_i,
  output logic [N_REQ-1:0]               req_ready_o,
  input  logic [N_REQ*FUNC_ID_W-1:0]     req_func_id_i,
  input  logic [N_REQ*LEN_W-1:0]         req_len_i,
  input  logic [N_REQ*N_WORDS*32-1:0]    req_args_i,
  output logic [N_REQ-1:0]               rsp_valid_o,
  output logic [31:0]                    rsp_ret_o,
  output logic [N_WORDS*32-1:0]          rsp_data_o,
  output logic                           busy_o,
  output logic                           call_valid_o,
  input  logic                           call_ready_i,
  output logic [31:0]                    call_data_o,
  output logic                           call_last_o,
  input  logic                           ret_valid_i,
  output logic                           ret_ready_o,
  input  logic [31:0]                    ret_data_i,
  input  logic                           ret_last_i
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ARGS,
    S_WAIT_RET,
    S_RET_DATA,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     g_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     k_q;
  logic [LEN_W-1:0]     j_q;
  logic [FUNC_ID_W-1:0] func_q;
  logic [31:0]          args_q [N_WORDS];
  logic [31:0]          res_q  [N_WORDS];
  logic [31:0]          res_d  [N_WORDS];
  logic [31:0]          ret_q;
  logic [31:0]          rsp_ret_q;
  logic [31:0]          rsp_data_q [N_WORDS];

  // Per-requester views of the packed request buses
  logic [FUNC_ID_W-1:0] fid_arr [N_REQ];
  logic [LEN_W-1:0]     len_arr [N_REQ];
  logic [31:0]          arg_arr [N_REQ][N_WORDS];

  for (genvar r = 0; r < N_REQ; r++) begin : g_unpack
    assign fid_arr[r] = req_func_id_i[r*FUNC_ID_W +: FUNC_ID_W];
    assign len_arr[r] = req_len_i[r*LEN_W +: LEN_W];
    for (genvar w = 0; w < N_WORDS; w++) begin : g_word
      assign arg_arr[r][w] = req_args_i[(r*N_WORDS + w)*32 +: 32];
    end
  end

  for (genvar w = 0; w < N_WORDS; w++) begin : g_rsp
    assign rsp_data_o[w*32 +: 32] = rsp_data_q[w];
  end

  assign rsp_ret_o = rsp_ret_q;
  assign busy_o    = (state_q != S_IDLE);

  // Round-robin search starting one past the last winner. ptr < N_REQ and
  // the offset is at most N_REQ, so a single conditional subtract wraps it.
  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W:0]   cand_sum;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(i + 1);
      if (cand_sum >= (PTR_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
      end
      if (!gnt_found && req_valid_i[cand_sum[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_sum[PTR_W-1:0];
      end
    end
  end

  logic [LEN_W-1:0] len_sel;
  logic [LEN_W-1:0] len_clamped;

  assign len_sel     = len_arr[gnt_idx];
  assign len_clamped = (len_sel > LEN_W'(N_WORDS)) ? LEN_W'(N_WORDS) : len_sel;

  logic args_last;
  logic ret_done;

  assign args_last = (k_q == (len_q - LEN_W'(1)));
  assign ret_done  = ret_valid_i && ret_last_i &&
                     ((state_q == S_WAIT_RET) || (state_q == S_RET_DATA));

  // Result buffer with the current output-array beat merged in; beats past
  // the buffer are accepted but leave it untouched.
  always_comb begin
    res_d = res_q;
    if ((state_q == S_RET_DATA) && ret_valid_i && (j_q < LEN_W'(N_WORDS))) begin
      res_d[j_q[IDX_W-1:0]] = ret_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    call_valid_o = 1'b0;
    call_data_o  = '0;
    call_last_o  = 1'b0;
    ret_ready_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready_o[gnt_idx] = 1'b1;
          state_d              = S_HDR;
        end
      end
      S_HDR: begin
        call_valid_o = 1'b1;
        call_data_o  = {8'(g_q), 8'(len_q), 16'(func_q)};
        call_last_o  = (len_q == '0);
        if (call_ready_i) begin
          state_d = (len_q == '0) ? S_WAIT_RET : S_ARGS;
        end
      end
      S_ARGS: begin
        call_valid_o = 1'b1;
        call_data_o  = args_q[k_q[IDX_W-1:0]];
        call_last_o  = args_last;
        if (call_ready_i && args_last) begin
          state_d = S_WAIT_RET;
        end
      end
      S_WAIT_RET: begin
        ret_ready_o = 1'b1;
        if (ret_valid_i) begin
          state_d = ret_last_i ? S_DONE : S_RET_DATA;
        end
      end
      S_RET_DATA: begin
        ret_ready_o = 1'b1;
        if (ret_valid_i && ret_last_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid_o[g_q] = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and the visible response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_W'(N_REQ - 1);
      g_q       <= '0;
      len_q     <= '0;
      k_q       <= '0;
      j_q       <= '0;
      rsp_ret_q <= '0;
      for (int w = 0; w < N_WORDS; w++) begin
        rsp_data_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            g_q   <= gnt_idx;
            len_q <= len_clamped;
            k_q   <= '0;
            j_q   <= '0;
          end
        end
        S_ARGS: begin
          if (call_ready_i) begin
            k_q <= k_q + LEN_W'(1);
          end
        end
        S_RET_DATA: begin
          if (ret_valid_i && (j_q < LEN_W'(N_WORDS))) begin
            j_q <= j_q + LEN_W'(1);
          end
        end
        S_DONE: begin
          ptr_q <= g_q;
        end
        default: ;
      endcase
      // A call that returns only its value publishes the beat directly.
      if (ret_done) begin
        rsp_ret_q  <= (state_q == S_WAIT_RET) ? ret_data_i : ret_q;
        rsp_data_q <= res_d;
      end
    end
  end

  // Payload registers; only meaningful once a grant has loaded them
  always_ff @(posedge clk_i) begin
    if ((state_q == S_IDLE) && gnt_found) begin
      func_q <= fid_arr[gnt_idx];
      for (int w = 0; w < N_WORDS; w++) begin
        args_q[w] <= arg_arr[gnt_idx][w];
        res_q[w]  <= '0;
      end
    end else begin
      res_q <= res_d;
    end
    if ((state_q == S_WAIT_RET) && ret_valid_i) begin
      ret_q <= ret_data_i;
    end
  end

endmodule

// File: tb/tb_dpi_call_arbiter.sv
module tb_dpi_call_arbiter;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [3:0]    req_valid_i;
  logic [3:0]    req_ready_o;
  logic [31:0]   req_func_id_i;
  logic [11:0]   req_len_i;
  logic [511:0]  req_args_i;
  logic [3:0]    rsp_valid_o;
  logic [31:0]   rsp_ret_o;
  logic [127:0]  rsp_data_o;
  logic          busy_o;
  logic          call_valid_o;
  logic          call_ready_i;
  logic [31:0]   call_data_o;
  logic          call_last_o;
  logic          ret_valid_i;
  logic          ret_ready_o;
  logic [31:0]   ret_data_i;
  logic          ret_last_i;

  logic [7:0]    fid_a  [4];
  logic [2:0]    len_a  [4];
  logic [127:0]  args_a [4];

  for (genvar r = 0; r < 4; r++) begin : g_pack
    assign req_func_id_i[r*8 +: 8]   = fid_a[r];
    assign req_len_i[r*3 +: 3]       = len_a[r];
    assign req_args_i[r*128 +: 128]  = args_a[r];
  end

  dpi_call_arbiter #(
    .N_REQ(4), .N_WORDS(4), .FUNC_ID_W(8), .LEN_W(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_func_id_i(req_func_id_i), .req_len_i(req_len_i), .req_args_i(req_args_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ret_o(rsp_ret_o), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o),
    .call_valid_o(call_valid_o), .call_ready_i(call_ready_i),
    .call_data_o(call_data_o), .call_last_o(call_last_o),
    .ret_valid_i(ret_valid_i), .ret_ready_o(ret_ready_o),
    .ret_data_i(ret_data_i), .ret_last_i(ret_last_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [127:0] TEST_ARGS = 128'hDEAD_BEEF_CAFE_BABE_1234_5678_9ABC_DEF0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_call  [8];
  int          n_call;
  logic [31:0] ret_beats [8];
  int          n_ret;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] r, input logic [7:0] fid,
                         input logic [2:0] len, input logic [127:0] args);
    fid_a[r]       = fid;
    len_a[r]       = len;
    args_a[r]      = args;
    req_valid_i[r] = 1'b1;
  endtask

  // Header followed by the first n words of TEST_ARGS
  task automatic load_test_beats(input logic [31:0] hdr, input int n);
    exp_call[0] = hdr;
    exp_call[1] = 32'h9ABC_DEF0;
    exp_call[2] = 32'h1234_5678;
    exp_call[3] = 32'hCAFE_BABE;
    exp_call[4] = 32'hDEAD_BEEF;
    n_call = n + 1;
  endtask

  task automatic wait_grant(input logic [1:0] exp_r, input bit drop);
    bit got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready_o != 4'b0000) begin
        check("grant", 128'(req_ready_o), 128'(4'b0001 << exp_r));
        got = 1'b1;
        @(negedge clk_i);
        if (drop) req_valid_i[exp_r] = 1'b0;
        break;
      end
      @(negedge clk_i);
    end
    if (!got) check("grant_timeout", 128'(0), 128'(1));
  endtask

  task automatic host_call(input bit stall);
    int idx = 0;
    for (int c = 0; c < 50; c++) begin
      call_ready_i = stall ? (c % 2 == 0) : 1'b1;
      #1;
      check("call_valid", 128'(call_valid_o), 128'(1));
      check("call_data", 128'(call_data_o), 128'(exp_call[idx]));
      check("ret_ready_idle", 128'(ret_ready_o), 128'(0));
      if (call_ready_i) begin
        check("call_last", 128'(call_last_o), 128'(idx == n_call - 1));
        idx++;
      end
      @(negedge clk_i);
      if (idx == n_call) break;
    end
    call_ready_i = 1'b0;
    if (idx != n_call) check("call_timeout", 128'(idx), 128'(n_call));
  endtask

  task automatic host_ret(input bit gaps);
    int idx = 0;
    for (int c = 0; c < 50; c++) begin
      if (gaps && (c % 2 == 1)) begin
        ret_valid_i = 1'b0;
        ret_data_i  = 32'h0000_0BAD;
        ret_last_i  = 1'b1;
      end else begin
        ret_valid_i = 1'b1;
        ret_data_i  = ret_beats[idx];
        ret_last_i  = (idx == n_ret - 1);
      end
      #1;
      check("ret_ready", 128'(ret_ready_o), 128'(1));
      check("call_valid_ret", 128'(call_valid_o), 128'(0));
      @(negedge clk_i);
      if (ret_valid_i) idx++;
      if (idx == n_ret) break;
    end
    ret_valid_i = 1'b0;
    ret_last_i  = 1'b0;
    if (idx != n_ret) check("ret_timeout", 128'(idx), 128'(n_ret));
  endtask

  task automatic check_rsp(input logic [1:0] r, input logic [31:0] ret, input logic [127:0] data);
    #1;
    check("rsp_valid", 128'(rsp_valid_o), 128'(4'b0001 << r));
    check("rsp_ret", 128'(rsp_ret_o), 128'(ret));
    check("rsp_data", rsp_data_o, data);
    @(negedge clk_i);
    #1;
    check("rsp_pulse", 128'(rsp_valid_o), 128'(0));
    check("rsp_ret_hold", 128'(rsp_ret_o), 128'(ret));
  endtask

  task automatic fair_call(input logic [1:0] r, input logic [31:0] hdr, input logic [31:0] arg);
    wait_grant(r, 1'b0);
    exp_call[0] = hdr;
    exp_call[1] = arg;
    n_call      = 2;
    host_call(1'b0);
    ret_beats[0] = 32'h100 + 32'(r);
    n_ret        = 1;
    host_ret(1'b0);
    check_rsp(r, 32'h100 + 32'(r), 128'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = '0;
    call_ready_i = 1'b0;
    ret_valid_i  = 1'b0;
    ret_data_i   = '0;
    ret_last_i   = 1'b0;
    for (int r = 0; r < 4; r++) begin
      fid_a[r]  = '0;
      len_a[r]  = '0;
      args_a[r] = '0;
    end
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_call_valid", 128'(call_valid_o), 128'(0));
    check("rst_ret_ready", 128'(ret_ready_o), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    check("rst_rsp_ret", 128'(rsp_ret_o), 128'(0));
    check("rst_rsp_data", rsp_data_o, 128'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Fairness: all four held high, order 0,1,2,3,0
    set_req(2'd0, 8'h20, 3'd1, 128'h0A0);
    set_req(2'd1, 8'h21, 3'd1, 128'h0A1);
    set_req(2'd2, 8'h22, 3'd1, 128'h0A2);
    set_req(2'd3, 8'h23, 3'd1, 128'h0A3);
    fair_call(2'd0, 32'h0001_0020, 32'h0A0);
    fair_call(2'd1, 32'h0101_0021, 32'h0A1);
    fair_call(2'd2, 32'h0201_0022, 32'h0A2);
    fair_call(2'd3, 32'h0301_0023, 32'h0A3);
    wait_grant(2'd0, 1'b0);
    req_valid_i = '0;
    exp_call[0] = 32'h0001_0020;
    exp_call[1] = 32'h0A0;
    n_call      = 2;
    host_call(1'b0);
    ret_beats[0] = 32'h100;
    n_ret        = 1;
    host_ret(1'b0);
    check_rsp(2'd0, 32'h100, 128'h0);

    // Single full-length call from requester 0
    set_req(2'd0, 8'h11, 3'd4, TEST_ARGS);
    wait_grant(2'd0, 1'b1);
    load_test_beats(32'h0004_0011, 4);
    host_call(1'b0);
    ret_beats[0] = 32'h1; ret_beats[1] = 32'h1; ret_beats[2] = 32'h2;
    ret_beats[3] = 32'h3; ret_beats[4] = 32'h4;
    n_ret = 5;
    host_ret(1'b0);
    check_rsp(2'd0, 32'h1, 128'h0000_0004_0000_0003_0000_0002_0000_0001);

    // Zero-length call from requester 2
    set_req(2'd2, 8'hAB, 3'd0, 128'h0);
    wait_grant(2'd2, 1'b1);
    exp_call[0] = 32'h0200_00AB;
    n_call      = 1;
    host_call(1'b0);
    ret_beats[0] = 32'h0000_CAFE;
    n_ret        = 1;
    host_ret(1'b0);
    check_rsp(2'd2, 32'h0000_CAFE, 128'h0);

    // Grant to 3, then requester 1 alone
    set_req(2'd3, 8'h44, 3'd1, 128'h3333);
    wait_grant(2'd3, 1'b1);
    exp_call[0] = 32'h0301_0044;
    exp_call[1] = 32'h0000_3333;
    n_call      = 2;
    host_call(1'b0);
    ret_beats[0] = 32'h3;
    n_ret        = 1;
    host_ret(1'b0);
    check_rsp(2'd3, 32'h3, 128'h0);

    set_req(2'd1, 8'h55, 3'd2, TEST_ARGS);
    wait_grant(2'd1, 1'b1);
    load_test_beats(32'h0102_0055, 2);
    host_call(1'b0);
    ret_beats[0] = 32'h9; ret_beats[1] = 32'h7;
    n_ret = 2;
    host_ret(1'b0);
    check_rsp(2'd1, 32'h9, 128'h7);

    // Stalled call and gapped return give the unstalled result
    set_req(2'd1, 8'h11, 3'd4, TEST_ARGS);
    wait_grant(2'd1, 1'b1);
    load_test_beats(32'h0104_0011, 4);
    host_call(1'b1);
    ret_beats[0] = 32'h1; ret_beats[1] = 32'h1; ret_beats[2] = 32'h2;
    ret_beats[3] = 32'h3; ret_beats[4] = 32'h4;
    n_ret = 5;
    host_ret(1'b1);
    check_rsp(2'd1, 32'h1, 128'h0000_0004_0000_0003_0000_0002_0000_0001);

    // Length 7 clamps to 4; six data beats, last two dropped
    set_req(2'd0, 8'h33, 3'd7, TEST_ARGS);
    wait_grant(2'd0, 1'b1);
    load_test_beats(32'h0004_0033, 4);
    host_call(1'b0);
    ret_beats[0] = 32'h77; ret_beats[1] = 32'h10; ret_beats[2] = 32'h20;
    ret_beats[3] = 32'h30; ret_beats[4] = 32'h40; ret_beats[5] = 32'h50;
    ret_beats[6] = 32'h60;
    n_ret = 7;
    host_ret(1'b0);
    check_rsp(2'd0, 32'h77, 128'h0000_0040_0000_0030_0000_0020_0000_0010);

    // Reset in the middle of the argument beats
    set_req(2'd3, 8'h44, 3'd4, TEST_ARGS);
    wait_grant(2'd3, 1'b1);
    call_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    call_ready_i = 1'b0;
    #1;
    check("pre_rst_data", 128'(call_data_o), 128'(32'hCAFE_BABE));
    rst_i = 1'b1;
    #1;
    check("mid_rst_call_valid", 128'(call_valid_o), 128'(0));
    check("mid_rst_busy", 128'(busy_o), 128'(0));
    check("mid_rst_rsp_ret", 128'(rsp_ret_o), 128'(0));
    check("mid_rst_rsp_data", rsp_data_o, 128'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    set_req(2'd0, 8'h05, 3'd0, 128'h0);
    set_req(2'd2, 8'h06, 3'd0, 128'h0);
    wait_grant(2'd0, 1'b1);
    exp_call[0] = 32'h0000_0005;
    n_call      = 1;
    host_call(1'b0);
    ret_beats[0] = 32'h55;
    n_ret        = 1;
    host_ret(1'b0);
    check_rsp(2'd0, 32'h55, 128'h0);
    wait_grant(2'd2, 1'b1);
    exp_call[0] = 32'h0200_0006;
    n_call      = 1;
    host_call(1'b0);
    ret_beats[0] = 32'h66;
    n_ret        = 1;
    host_ret(1'b0);
    check_rsp(2'd2, 32'h66, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpi_call_arbiter.md
Name: dpi_call_arbiter

Overview:
- Shares one host-side DPI call channel among N_REQ hardware requesters.
- Each request carries a function ID and a packed open-array argument of up to N_WORDS 32-bit elements.
- Round-robin grant; the granted request is serialized into a header plus argument beats. The return beats (return value, then output open-array words) are deserialized into a packed result.
- Sits between the per-call-site packed wrappers and the host transport bridge. Exactly one call is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- N_WORDS, 4, max open-array elements per call; element i lives at bits [i*32+:32].
- FUNC_ID_W, 8, function-ID width (at most 16).
- LEN_W, $clog2(N_WORDS+1), element-count field width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  N_REQ  per-requester call request; held until the matching req_ready_o.
- req_ready_o  out  N_REQ  one-hot grant/accept strobe.
- req_func_id_i  in  N_REQ*FUNC_ID_W  function ID per requester.
- req_len_i  in  N_REQ*LEN_W  element count per requester.
- req_args_i  in  N_REQ*N_WORDS*32  packed input array per requester.
- rsp_valid_o  out  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_ret_o  out  32  return value; holds until the next completion.
- rsp_data_o  out  N_WORDS*32  packed output array; holds until the next completion.
- busy_o  out  1  high whenever state is not IDLE.
- call_valid_o  out  1  host call beat valid.
- call_ready_i  in  1  host accepts the beat.
- call_data_o  out  32  call beat payload.
- call_last_o  out  1  final beat of the call.
- ret_valid_i  in  1  host return beat valid.
- ret_ready_o  out  1  block accepts the return beat.
- ret_data_i  in  32  return beat payload.
- ret_last_i  in  1  final return beat.

Behaviour:
- Reset (async, immediate, any state):
  - State goes to IDLE.
  - All outputs are 0, including rsp_ret_o and rsp_data_o.
  - Grant pointer is set to N_REQ-1, so requester 0 wins first.
- States: IDLE, HDR, ARGS, WAIT_RET, RET_DATA, DONE.
- IDLE:
  - Grant g = first set req_valid_i searching from ptr+1, wrapping modulo N_REQ.
  - req_ready_o[g] is driven combinationally in the same cycle.
  - On that edge, latch func_id, args and len. len is clamped to N_WORDS if larger.
  - Clear the result buffer to 0, then go to HDR.
  - No valid requests: stay in IDLE.
- HDR:
  - call_valid_o=1.
  - call_data_o header = {g[7:0] at [31:24], len at [23:16], zero-extended func_id at [15:0]}.
  - call_last_o=1 iff len==0.
  - On handshake: go to ARGS, or to WAIT_RET if len==0.
- ARGS:
  - Beat k carries args word k, for k = 0..len-1. call_last_o=1 on k==len-1.
  - Advance only on call_valid_o && call_ready_i.
  - call_data_o and call_last_o stay stable while stalled.
  - After the last beat, go to WAIT_RET.
- WAIT_RET:
  - ret_ready_o=1.
  - The first beat is the return value.
  - ret_last_i: go to DONE; otherwise go to RET_DATA.
- RET_DATA:
  - ret_ready_o=1.
  - Beat j is written to result word j if j<N_WORDS. Beats with j>=N_WORDS are consumed and dropped.
  - ret_last_i: go to DONE.
  - Words never received remain 0.
- DONE (one cycle):
  - rsp_valid_o[g]=1.
  - rsp_ret_o and rsp_data_o update on entry to DONE.
  - Set ptr=g, go to IDLE.
- call_valid_o and ret_ready_o are never asserted outside their own states.
- Minimum latency, grant to rsp_valid_o with zero stalls: 1 (HDR) + len (ARGS) + 1 (ret value) + data beats + 1 (DONE) cycles.
- A requester dropping req_valid_i after its grant has no effect on the in-flight call.
- A requester re-asserting req_valid_i before its own rsp_valid_o is legal; it is arbitrated normally after DONE.
- Simultaneous new requests during a call wait in their requesters. No request is ever lost.
- Round-robin fairness: with all requesters continuously requesting, each gets exactly one call per N_REQ calls.

Test Plan:
- Single call, g=0, func_id 8'h11, len 4, args 128'hDEAD_BEEF_CAFE_BABE_1234_5678_9ABC_DEF0.
  - Required call beats: 32'h0004_0011, 9ABCDEF0, 12345678, CAFEBABE, DEADBEEF; call_last_o on the 5th beat only.
  - Host returns 32'h1, 1, 2, 3, 4 (last) -> rsp_ret_o=1, rsp_data_o=128'h4_0000_0003_0000_0002_0000_0001, rsp_valid_o=4'b0001 for one cycle.
- len 0, requester 2: single header beat 32'h0200_00xx with call_last_o=1.
  - Host returns one beat 32'hCAFE, last -> rsp_ret_o=32'hCAFE, rsp_data_o=0.
- All four req_valid_i held high for 5 calls -> grant order 0,1,2,3,0.
  - Requester 1 alone after a grant to 3 -> granted next.
- call_ready_i toggling 1-0-1 and ret_valid_i gaps -> payloads stable while stalled, no beat duplicated or skipped, result identical to the unstalled case.
- Response with 6 data beats at N_WORDS=4 -> beats 5-6 consumed (ret_ready_o=1), dropped; rsp_data_o holds beats 1-4.
  - req_len 7 -> clamped: header len field = 4, 4 argument beats.
- rst_i asserted mid-ARGS (after 2 beats) -> same cycle: call_valid_o=0, busy_o=0, rsp outputs 0.
  - After release, the next grant goes to requester 0.
